// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
//   PWM generator for the pen-lift servo. Holds a pulse width that ramps by
//   STEP once per PWM period towards the end-stop chosen by servo_dir, and
//   reports when either end-stop is reached. All state advances only on
//   cycles where clk_en is high.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   clk_en     module enabling tick
//   servo_dir  direction command (UP / DOWN / STAY; other codes act as STAY)
//   pwm_out    registered PWM output
//   width      current pulse width in ticks
//   at_up      width is at the pen-up end-stop
//   at_down    width is at the pen-down end-stop

package servo_pwm_pkg;
    typedef enum logic [1:0] {
        SERVO_DIR_STAY = 2'd0,
        SERVO_DIR_UP   = 2'd1,
        SERVO_DIR_DOWN = 2'd2
    } ServoDir_t;
endpackage

module servo_pwm_driver
    import servo_pwm_pkg::*;
#(
    parameter int PERIOD_TICKS = 2000,
    parameter int WIDTH_UP     = 100,
    parameter int WIDTH_DOWN   = 200,
    parameter int STEP         = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  ServoDir_t        servo_dir,
    output logic             pwm_out,
    output logic [CNT_W-1:0] width,
    output logic             at_up,
    output logic             at_down
);

    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PERIOD_TICKS - 1);
    localparam logic [CNT_W-1:0] W_UP   = CNT_W'(WIDTH_UP);
    localparam logic [CNT_W-1:0] W_DOWN = CNT_W'(WIDTH_DOWN);

    // One extra bit so width-STEP going negative and width+STEP carrying
    // out are both visible before saturation.
    localparam logic [CNT_W:0] STEP_X   = (CNT_W+1)'(STEP);
    localparam logic [CNT_W:0] W_UP_X   = (CNT_W+1)'(WIDTH_UP);
    localparam logic [CNT_W:0] W_DOWN_X = (CNT_W+1)'(WIDTH_DOWN);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] width_q, width_nxt;
    logic             pwm_q;
    logic             boundary;

    logic [CNT_W:0]   dn_sum, up_sum;
    logic [CNT_W-1:0] dn_sat, up_sat;

    // Boundary = the enabled cycle on which the counter wraps to 0. Width and
    // direction only change here so every period carries one fixed width.
    assign boundary = clk_en && (cnt == P_LAST);

    // Saturating step towards each end-stop. RAMP_UP narrows the pulse
    // (pen up uses the shorter width), RAMP_DOWN widens it.
    assign dn_sum = {1'b0, width_q} - STEP_X;
    assign up_sum = {1'b0, width_q} + STEP_X;

    always_comb begin
        dn_sat = dn_sum[CNT_W-1:0];
        if (dn_sum[CNT_W] || (dn_sum < W_UP_X))
            dn_sat = W_UP;
        up_sat = up_sum[CNT_W-1:0];
        if (up_sum > W_DOWN_X)
            up_sat = W_DOWN;
    end

    // Counter next value, independent of clk_en (gated at the register).
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == P_LAST)
            cnt_nxt = '0;
    end

    // Next-state / next-width. Entering a ramp state applies its first
    // step on the same boundary, so width follows state_nxt, not state.
    always_comb begin
        state_nxt = state;
        width_nxt = width_q;
        if (boundary) begin
            case (servo_dir)
                SERVO_DIR_UP:   state_nxt = RAMP_UP;
                SERVO_DIR_DOWN: state_nxt = RAMP_DOWN;
                default:        state_nxt = HOLD;
            endcase
            case (state_nxt)
                RAMP_UP:   width_nxt = dn_sat;
                RAMP_DOWN: width_nxt = up_sat;
                default:   width_nxt = width_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= HOLD;
            cnt     <= '0;
            width_q <= W_DOWN;
            pwm_q   <= 1'b0;
        end else if (clk_en) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            width_q <= width_nxt;
            // Compare against the values the registers are about to take,
            // so the pin lines up with the counter and the new width covers
            // the whole period starting at the wrap.
            pwm_q   <= (cnt_nxt < width_nxt);
        end
    end

    assign pwm_out = pwm_q;
    assign width   = width_q;
    assign at_up   = (width_q == W_UP);
    assign at_down = (width_q == W_DOWN);

endmodule

// File: tb/tb_servo_pwm_driver.sv
module tb_servo_pwm_driver;
    import servo_pwm_pkg::*;

    localparam int P  = 20;
    localparam int WU = 4;
    localparam int WD = 10;
    localparam int S  = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_en = 1'b1;
    ServoDir_t     servo_dir = SERVO_DIR_STAY;
    logic          pwm_out;
    logic [CW-1:0] width;
    logic          at_up;
    logic          at_down;

    int checks = 0;
    int errors = 0;
    int en_mode = 0;   // 0: always, 1: every 3rd clk, 2: random
    int en_phase = 0;
    int hi_acc = 0;

    servo_pwm_driver #(
        .PERIOD_TICKS(P), .WIDTH_UP(WU), .WIDTH_DOWN(WD), .STEP(S), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .servo_dir(servo_dir),
        .pwm_out(pwm_out), .width(width), .at_up(at_up), .at_down(at_down)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count enabled ticks since reset. Phase within the period is
    // t mod P; each completed period applies one saturating step chosen by
    // the direction present at the wrap tick. Pin is high while phase < width,
    // except before the first tick after reset.
    int m_t = 0;
    bit m_tick = 1'b0;
    int m_w = WD;

    function automatic int ramp(input int w, input logic [1:0] d);
        if (d == 2'd1) return (w - S < WU) ? WU : w - S;
        if (d == 2'd2) return (w + S > WD) ? WD : w + S;
        return w;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_t    <= 0;
            m_tick <= 1'b0;
            m_w    <= WD;
        end else if (clk_en) begin
            m_t    <= m_t + 1;
            m_tick <= 1'b1;
            if ((m_t + 1) % P == 0)
                m_w <= ramp(m_w, servo_dir);
        end
    end

    always @(negedge clk) begin
        chk("sb_pwm",     int'(pwm_out), int'(m_tick && ((m_t % P) < m_w)));
        chk("sb_width",   int'(width),   m_w);
        chk("sb_at_up",   int'(at_up),   int'(m_w == WU));
        chk("sb_at_down", int'(at_down), int'(m_w == WD));
    end

    task automatic step();
        @(negedge clk);
        if (pwm_out) hi_acc++;
        case (en_mode)
            0: clk_en = 1'b1;
            1: begin
                clk_en = (en_phase == 0);
                en_phase = (en_phase + 1) % 3;
            end
            default: clk_en = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b0;
        servo_dir = SERVO_DIR_STAY;
        en_phase = 0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    task automatic window(input int n, output int hi);
        int h0;
        h0 = hi_acc;
        repeat (n) step();
        hi = hi_acc - h0;
    endtask

    initial begin
        int hi;
        int h0;
        int exp_hi[4];
        int exp_w[4];
        exp_hi = '{8, 6, 4, 4};
        exp_w  = '{6, 4, 4, 4};

        // Reset state
        #1 reset = 1'b0;
        repeat (3) step();
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_width", int'(width), 10);
        chk("rst_at_down", int'(at_down), 1);
        chk("rst_at_up", int'(at_up), 0);
        reset = 1'b1;

        // STAY: 10/20 duty, first rise one tick after release
        step();
        chk("first_rise", int'(pwm_out), 1);
        repeat (P - 1) step();
        for (int k = 0; k < 3; k++) begin
            window(P, hi);
            chk("stay_high", hi, 10);
            chk("stay_width", int'(width), 10);
        end

        // UP from reset: 8,6,4,4
        do_reset();
        servo_dir = SERVO_DIR_UP;
        window(P, hi);
        chk("up_w1", int'(width), 8);
        chk("up_at_up_lo", int'(at_up), 0);
        for (int k = 0; k < 4; k++) begin
            window(P, hi);
            chk("up_high", hi, exp_hi[k]);
            chk("up_width", int'(width), exp_w[k]);
        end
        chk("up_at_up", int'(at_up), 1);
        chk("up_at_down", int'(at_down), 0);

        // UP x2, STAY x3, DOWN x3
        do_reset();
        servo_dir = SERVO_DIR_UP;
        window(P, hi);
        window(P, hi);
        chk("mix_w6", int'(width), 6);
        servo_dir = SERVO_DIR_STAY;
        for (int k = 0; k < 3; k++) begin
            window(P, hi);
            chk("mix_hold", int'(width), 6);
        end
        chk("mix_at_down_lo", int'(at_down), 0);
        servo_dir = SERVO_DIR_DOWN;
        window(P, hi);
        chk("mix_d8", int'(width), 8);
        window(P, hi);
        chk("mix_d10", int'(width), 10);
        window(P, hi);
        chk("mix_d10b", int'(width), 10);
        chk("mix_at_down", int'(at_down), 1);

        // Mid-period toggles restored before the wrap have no effect
        do_reset();
        window(P, hi);
        h0 = hi_acc;
        repeat (5) step();
        servo_dir = SERVO_DIR_UP;
        repeat (3) step();
        servo_dir = SERVO_DIR_DOWN;
        repeat (3) step();
        servo_dir = SERVO_DIR_STAY;
        repeat (9) step();
        chk("toggle_high", hi_acc - h0, 10);
        chk("toggle_width", int'(width), 10);
        window(P, hi);
        chk("toggle_high2", hi, 10);

        // clk_en every 3rd clk: 60-cycle period
        en_mode = 1;
        do_reset();
        repeat (120) step();
        window(60, hi);
        chk("div3_high", hi, 30);
        servo_dir = SERVO_DIR_UP;
        repeat (60) step();
        servo_dir = SERVO_DIR_STAY;
        window(60, hi);
        chk("div3_width", int'(width), 8);
        chk("div3_high8", hi, 24);

        // Async reset mid-pulse during RAMP_UP at width 6
        en_mode = 0;
        do_reset();
        servo_dir = SERVO_DIR_UP;
        window(P, hi);
        window(P, hi);
        repeat (2) step();
        chk("mid_pre_pwm", int'(pwm_out), 1);
        chk("mid_pre_width", int'(width), 6);
        #2 reset = 1'b0;
        #1;
        chk("async_pwm", int'(pwm_out), 0);
        chk("async_width", int'(width), 10);
        chk("async_at_down", int'(at_down), 1);
        chk("async_at_up", int'(at_up), 0);
        repeat (2) step();
        servo_dir = SERVO_DIR_STAY;
        reset = 1'b1;
        window(P, hi);
        window(P, hi);
        chk("post_rst_high", hi, 10);
        chk("post_rst_width", int'(width), 10);

        // Randomized run with the per-cycle model check
        en_mode = 2;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step();
            if (i % 1000 == 999) en_mode = (en_mode + 1) % 3;
            if ($urandom_range(0, 24) == 0)
                servo_dir = ServoDir_t'($urandom_range(0, 3));
            if ($urandom_range(0, 799) == 0) begin
                #2 reset = 1'b0;
                #1 chk("rand_rst_width", int'(width), WD);
                step();
                step();
                reset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
